// File: rtl/arith_pkg.sv
// Shared arithmetic-unit definitions.
// Contents:
//   state_t          - sequencer states for the restoring divider
//   DEF_DIVIDEND_W   - default dividend/quotient width
//   DEF_DIVISOR_W    - default divisor/remainder width
//   DIVZ_QUOTIENT    - quotient reported on divide-by-zero (all ones)
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DONE   = 2'd2,
    DONE_Z = 2'd3
  } state_t;

  localparam int DEF_DIVIDEND_W = 8;
  localparam int DEF_DIVISOR_W  = 4;

  localparam logic [DEF_DIVIDEND_W-1:0] DIVZ_QUOTIENT = '1;

endpackage

// File: rtl/seq_divider_8x4_div_step.sv
// One combinational restoring-division iteration.
// Ports:
//   rem_in   - current partial remainder (DIVISOR_W+1 bits)
//   bit_in   - next dividend bit shifted into the remainder
//   divisor  - divisor
//   rem_out  - partial remainder after the trial subtraction/restore
//   q_bit    - quotient bit produced by this iteration
module div_step #(
  parameter int DIVISOR_W = 4
) (
  input  logic [DIVISOR_W:0]   rem_in,
  input  logic                 bit_in,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W:0]   rem_out,
  output logic                 q_bit
);

  logic [DIVISOR_W+1:0] shifted;
  logic [DIVISOR_W:0]   diff;
  logic                 fits;

  always_comb begin
    shifted = {rem_in, bit_in};
    // The shifted remainder is always < 2*divisor, so when the subtraction is
    // non-negative the difference fits in DIVISOR_W+1 bits.
    fits    = (shifted >= (DIVISOR_W+2)'(divisor));
    diff    = shifted[DIVISOR_W:0] - {1'b0, divisor};
    rem_out = fits ? diff : shifted[DIVISOR_W:0];
    q_bit   = fits;
  end

endmodule

// File: rtl/seq_divider_8x4.sv
// Sequential restoring divider, one quotient bit per clock.
// Ports:
//   clk, rst     - clock (rising edge), asynchronous active-high reset
//   start        - division request, accepted only when idle
//   dividend     - unsigned dividend, captured on the accepted start edge
//   divisor      - unsigned divisor, captured on the accepted start edge
//   busy         - high while a division is in progress
//   done         - one-cycle pulse when quotient/remainder/div_by_zero update
//   quotient     - registered quotient (all ones on divide-by-zero)
//   remainder    - registered remainder (dividend low bits on divide-by-zero)
//   div_by_zero  - registered divide-by-zero flag
module seq_divider_8x4
  import arith_pkg::*;
#(
  parameter int DIVIDEND_W = DEF_DIVIDEND_W,
  parameter int DIVISOR_W  = DEF_DIVISOR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int CNT_W = $clog2(DIVIDEND_W + 1);

  state_t state_reg, state_next;

  // dvd_reg starts as the dividend and fills with quotient bits from the LSB
  // as dividend bits leave through the MSB.
  logic [DIVIDEND_W-1:0] dvd_reg;
  logic [DIVISOR_W-1:0]  dvs_reg;
  logic [DIVISOR_W:0]    rem_reg;
  logic [CNT_W-1:0]      cnt_reg;

  logic [DIVIDEND_W-1:0] quotient_reg;
  logic [DIVISOR_W-1:0]  remainder_reg;
  logic                  div_by_zero_reg;
  logic                  done_reg;

  logic [DIVISOR_W:0]    step_rem;
  logic                  step_q;

  div_step #(
    .DIVISOR_W (DIVISOR_W)
  ) u_step (
    .rem_in  (rem_reg),
    .bit_in  (dvd_reg[DIVIDEND_W-1]),
    .divisor (dvs_reg),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = (divisor == '0) ? DONE_Z : RUN;
        end
      end
      RUN: begin
        if (cnt_reg == CNT_W'(1)) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      DONE_Z:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath and output registers. Results are published on the edge that
  // leaves DONE/DONE_Z, so done and the new values appear together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd_reg         <= '0;
      dvs_reg         <= '0;
      rem_reg         <= '0;
      cnt_reg         <= '0;
      quotient_reg    <= '0;
      remainder_reg   <= '0;
      div_by_zero_reg <= 1'b0;
      done_reg        <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            // Dividend is captured for the zero-divisor case as well, since
            // its low bits become the reported remainder.
            dvd_reg <= dividend;
            dvs_reg <= divisor;
            rem_reg <= '0;
            cnt_reg <= CNT_W'(DIVIDEND_W);
          end
        end
        RUN: begin
          rem_reg <= step_rem;
          dvd_reg <= {dvd_reg[DIVIDEND_W-2:0], step_q};
          cnt_reg <= cnt_reg - CNT_W'(1);
        end
        DONE: begin
          quotient_reg    <= dvd_reg;
          remainder_reg   <= rem_reg[DIVISOR_W-1:0];
          div_by_zero_reg <= 1'b0;
          done_reg        <= 1'b1;
        end
        DONE_Z: begin
          quotient_reg    <= '1;
          remainder_reg   <= dvd_reg[DIVISOR_W-1:0];
          div_by_zero_reg <= 1'b1;
          done_reg        <= 1'b1;
        end
        default: begin
          done_reg <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = (state_reg != IDLE);
  assign done        = done_reg;
  assign quotient    = quotient_reg;
  assign remainder   = remainder_reg;
  assign div_by_zero = div_by_zero_reg;

endmodule

// File: tb/tb_seq_divider_8x4.sv
module tb_seq_divider_8x4;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int total;
  int bad;

  seq_divider_8x4 dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Issue one division and check busy, latency, results and done width.
  // inj_at >= 0 drives a competing start (50/5) at that cycle count while busy.
  task automatic run_div(input logic [7:0] a, input logic [3:0] b,
                         input logic [7:0] eq, input logic [3:0] er, input logic ez,
                         input int elat, input int inj_at, input bit quiet);
    int lat;
    bit seen;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = ~a;
    divisor  = ~b;
    chk("busy_rise", busy, 1);
    lat  = 0;
    seen = 0;
    while (!seen && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (done) seen = 1;
      if (lat == inj_at) begin
        start    = 1'b1;
        dividend = 8'd50;
        divisor  = 4'd5;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk("done_seen", seen, 1);
    chk("latency", lat, elat);
    chk("quotient", quotient, eq);
    chk("remainder", remainder, er);
    chk("div_by_zero", div_by_zero, ez);
    chk("busy_at_done", busy, 0);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    if (!quiet)
      $display("div %0d/%0d -> q=%0d r=%0d z=%0d lat=%0d", a, b, quotient, remainder, div_by_zero, lat);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [3:0] b;
    logic [7:0] q;
    logic [3:0] r;
  } vec_t;

  vec_t vecs[7];

  initial begin
    total    = 0;
    bad      = 0;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    vecs[0] = '{8'd60,  4'd6,  8'd10,  4'd0};
    vecs[1] = '{8'd15,  4'd5,  8'd3,   4'd0};
    vecs[2] = '{8'd0,   4'd1,  8'd0,   4'd0};
    vecs[3] = '{8'd1,   4'd1,  8'd1,   4'd0};
    vecs[4] = '{8'd255, 4'd7,  8'd36,  4'd3};
    vecs[5] = '{8'd255, 4'd1,  8'd255, 4'd0};
    vecs[6] = '{8'd14,  4'd15, 8'd0,   4'd14};

    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    run_div(8'd225, 4'd15, 8'd15, 4'd0, 1'b0, 9, -1, 1'b0);

    foreach (vecs[i])
      run_div(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, 1'b0, 9, -1, 1'b0);

    run_div(8'd200, 4'd0, 8'd255, 4'd8, 1'b1, 1, -1, 1'b0);
    run_div(8'd200, 4'd3, 8'd66, 4'd2, 1'b0, 9, -1, 1'b0);

    // Competing start during RUN, then during the DONE cycle: both ignored.
    run_div(8'd100, 4'd7, 8'd14, 4'd2, 1'b0, 9, 4, 1'b0);
    run_div(8'd100, 4'd7, 8'd14, 4'd2, 1'b0, 9, 8, 1'b0);
    repeat (12) begin
      @(negedge clk);
      chk("no_extra_done", done, 0);
    end

    // Abort mid-operation with reset.
    @(negedge clk);
    dividend = 8'd255;
    divisor  = 4'd2;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_quotient", quotient, 0);
    chk("abort_remainder", remainder, 0);
    chk("abort_dbz", div_by_zero, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chk("abort_no_done", done, 0);
    end
    $display("abort 255/2 with reset -> q=%0d r=%0d busy=%0d", quotient, remainder, busy);
    run_div(8'd9, 4'd4, 8'd2, 4'd1, 1'b0, 9, -1, 1'b0);

    // Exhaustive sweep of non-zero divisors against a/b and a%b.
    for (int a = 0; a < 256; a++) begin
      for (int b = 1; b < 16; b++) begin
        run_div(8'(a), 4'(b), 8'(a / b), 4'(a % b), 1'b0, 9, -1, 1'b1);
      end
      $display("sweep dividend=%0d divisors 1..15 checked, bad so far=%0d", a, bad);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_divider_8x4.md
Name: seq_divider_8x4

Overview:
- Sequential restoring divider: unsigned DIVIDEND_W-bit dividend divided by unsigned DIVISOR_W-bit divisor.
- Produces the quotient and remainder, one quotient bit per clock.
- It is the inverse-operation companion to the combinational 4x4 multiplier in the arithmetic unit, so P = A*B can be checked back as P / B = A, remainder 0.
- A start/busy/done handshake lets the datapath controller issue divisions and wait for results.

Parameters:
- DIVIDEND_W, 8, width of dividend and quotient.
- DIVISOR_W, 4, width of divisor and remainder.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request a division; sampled only in IDLE.
- dividend  input  DIVIDEND_W  unsigned dividend; captured on the accepted start edge.
- divisor  input  DIVISOR_W  unsigned divisor; captured on the accepted start edge.
- busy  output  1  high whenever state != IDLE; start is ignored while high.
- done  output  1  one-cycle pulse when results are valid.
- quotient  output  DIVIDEND_W  registered quotient.
- remainder  output  DIVISOR_W  registered remainder.
- div_by_zero  output  1  registered flag; set with done if divisor was 0.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; busy, done, quotient, remainder, div_by_zero all 0; counter and internal registers 0. Reset asserted mid-operation aborts the division immediately. No done is produced for the aborted operation.
- States:
  - IDLE: busy=0. start=1 with divisor!=0: load dividend shift reg and divisor reg, clear partial remainder (DIVISOR_W+1 bits), counter=DIVIDEND_W, go to RUN. start=1 with divisor==0: go to DONE_Z.
  - RUN: each cycle, shift {partial remainder, dividend reg} left by 1, then trial-subtract the divisor from the partial remainder.
    - If the result is non-negative, keep the difference and shift in quotient bit 1.
    - Otherwise restore the partial remainder and shift in 0.
    - Decrement counter. When counter reaches 0 after the iteration, go to DONE.
  - DONE: latch quotient, remainder and div_by_zero=0 into output registers; done=1 for exactly this cycle; go to IDLE.
  - DONE_Z: quotient = all ones, remainder = dividend[DIVISOR_W-1:0], div_by_zero=1; done=1 for this cycle; go to IDLE.
- Latency:
  - Normal division: done is high in the cycle after DIVIDEND_W+1 rising edges following the start edge, i.e. 9 cycles for the defaults.
  - Divide-by-zero: done is high in the cycle after the next edge (latency 1).
- Handshake:
  - start while busy=1, including the DONE/DONE_Z cycle, is ignored. The operation in flight is unaffected.
  - Back-to-back operations: start may be asserted in the first IDLE cycle after done.
- Output hold: quotient, remainder and div_by_zero hold their values from done until the next done. They are not cleared on a new start.
- Input stability: dividend and divisor may change freely after the start edge; the block uses only its captured copies.
- Width rules:
  - Partial remainder is DIVISOR_W+1 bits so the trial subtraction never overflows. The final remainder is always < divisor and fits DIVISOR_W bits.
  - The quotient needs the full DIVIDEND_W bits, e.g. 255/1 = 255.
- Functional identity: when div_by_zero=0, quotient*divisor + remainder == dividend and remainder < divisor.

Decomposition:
- Shared package arith_pkg:
  - State enum: IDLE, RUN, DONE, DONE_Z.
  - Default width constants DIVIDEND_W=8, DIVISOR_W=4.
  - Divide-by-zero quotient constant (all ones).
- Sub-module div_step: one combinational restoring iteration.
  - Inputs: partial remainder, next dividend bit, divisor.
  - Outputs: new partial remainder, quotient bit.
  - The top level holds the FSM, counter and registers.

Test Plan:
- Reset, then start with 225 / 15 -> busy rises the next cycle; done 9 cycles after the start edge; quotient=15, remainder=0, div_by_zero=0.
- Sweep pairs 60/6, 15/5, 0/1, 1/1, 255/7, 255/1, 14/15 -> quotient/remainder 10/0, 3/0, 0/0, 1/0, 36/3, 255/0, 0/14; done exactly one cycle each time.
- 200 / 0 -> done 1 cycle after start; quotient=255, remainder=8, div_by_zero=1. A following 200 / 3 gives 66 r 2 with div_by_zero=0.
- Start 100 / 7, then pulse start with 50 / 5 at cycle 4 -> second request ignored; result 14 r 2; only one done pulse.
- Start 255 / 2, assert rst at cycle 5 -> all outputs 0 immediately; no done. After release, 9 / 4 yields 2 r 1.
- Exhaustive loop over all 256x15 non-zero-divisor pairs, checked against the reference model quotient = a/b, remainder = a%b -> zero mismatches.
